tdm_demux: RTL and testbench
============================

// Module: tdm_demux
// PURPOSE
//  Time-division demultiplexer; the receive-side counterpart of the channel mux.
//  Takes one shared WIDTH-bit word stream, one word per slot, with slot 0 flagged by FRAME_START.
//  Steers each word into its own channel register in round-robin order.
//  Sits between the shared TDM bus and the per-channel consumers.
// PARAMETERS
//  WIDTH     8   bits per word / per channel register
//  CHANNELS  4   slots per frame (>=2); slot counter width = $clog2(CHANNELS)
// PORTS
//  CLK          in   1                 system clock, all logic on rising edge
//  RST          in   1                 synchronous, active-high reset
//  DIN          in   WIDTH             word on shared bus
//  DIN_VALID    in   1                 DIN holds a word this cycle
//  FRAME_START  in   1                 qualifies DIN as slot 0; ignored unless DIN_VALID=1
//  CH_DATA      out  CHANNELS*WIDTH    channel k at [k*WIDTH +: WIDTH], registered
//  CH_STROBE    out  CHANNELS          1-cycle pulse, bit k = channel k updated
//  FRAME_DONE   out  1                 1-cycle pulse, last slot of frame captured
//  LOCKED       out  1                 1 = FSM in LOCK state
//  SYNC_ERR     out  1                 1-cycle pulse, framing violation detected
// BEHAVIOUR
//  Reset: RST=1 at an edge -> CH_DATA=0, CH_STROBE=0, FRAME_DONE=0, LOCKED=0, SYNC_ERR=0, slot=0, state=HUNT.
//   RST overrides all inputs that cycle, including mid-frame.
//  Accepted word: DIN_VALID=1 at an edge; a cycle with DIN_VALID=0 changes nothing (strobes return to 0).
//  Capture latency: 1 cycle. CH_DATA[k] and CH_STROBE[k] update on the edge that samples the word.
//   Unaddressed channels hold their value.
//  FSM states: HUNT, LOCK.
//  HUNT:
//   - valid word with FRAME_START=0 -> discarded, no strobe, stay HUNT.
//   - valid word with FRAME_START=1 -> capture into ch0, strobe[0], slot<=1, go LOCK.
//  LOCK, expected slot s (1..CHANNELS-1):
//   - valid word, FRAME_START=0 -> capture into ch s, strobe[s].
//     s=CHANNELS-1 -> FRAME_DONE=1 same edge, slot<=0 (wrap); else slot<=s+1.
//   - valid word, FRAME_START=1 -> early resync: SYNC_ERR=1, capture into ch0, strobe[0], slot<=1, stay LOCK.
//     No FRAME_DONE for the truncated frame.
//  LOCK, expected slot 0:
//   - valid word, FRAME_START=1 -> capture into ch0, strobe[0], slot<=1.
//   - valid word, FRAME_START=0 -> lost sync: SYNC_ERR=1, word discarded, no strobe, slot<=0, go HUNT.
//  Strobes are one-hot or zero; SYNC_ERR may coincide with strobe[0] only.
//  FRAME_DONE never coincides with SYNC_ERR.
//  Gaps (DIN_VALID=0) of any length inside a frame are legal and do not advance the slot.
//  CHANNELS=1 is not supported.
// TESTING (WIDTH=8, CHANNELS=4)
//  1 Reset then clean frame A1,B2,C3,D4 (FS on A1), back-to-back
//    -> ch0..3=A1,B2,C3,D4; strobe 0001,0010,0100,1000; FRAME_DONE with D4; LOCKED=1 after A1.
//  2 In HUNT, words 11,22 without FS, then 33 with FS
//    -> 11,22 dropped, no strobes; ch0=33, LOCKED=1.
//  3 Locked: FS+10, 20, then FS+30
//    -> SYNC_ERR=1 and strobe[0] on 30, ch0=30, ch1=20, no FRAME_DONE, next word lands in ch1.
//  4 Full frame, then slot-0 word 55 without FS
//    -> SYNC_ERR=1, 55 discarded, LOCKED=0, ch0 unchanged.
//  5 Frame with 3-cycle DIN_VALID gaps between words
//    -> same results as test 1; no strobes during gaps.
//  6 RST=1 after 2 words of a frame
//    -> all outputs 0 next edge, HUNT; next FS frame captured normally.

Source files
------------

// File: rtl/tdm_demux.sv
// tdm_demux: time-division demultiplexer. It steers a shared word stream into per-channel registers.
// Rev 1.0: initial release.
`default_nettype none

module tdm_demux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [WIDTH-1:0]          DIN,
  input  logic                      DIN_VALID,
  input  logic                      FRAME_START,
  output logic [CHANNELS*WIDTH-1:0] CH_DATA,
  output logic [CHANNELS-1:0]       CH_STROBE,
  output logic                      FRAME_DONE,
  output logic                      LOCKED,
  output logic                      SYNC_ERR
);

  localparam int SLOT_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [0:0]        HUNT      = 1'b0;
  localparam logic [0:0]        LOCK      = 1'b1;
  localparam logic [SLOT_W-1:0] SLOT_ZERO = '0;
  localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(CHANNELS - 1);

  logic [0:0]                state_q,      state_d;
  logic [SLOT_W-1:0]         slot_q,       slot_d;
  logic [CHANNELS*WIDTH-1:0] ch_data_q,    ch_data_d;
  logic [CHANNELS-1:0]       ch_strobe_q,  ch_strobe_d;
  logic                      frame_done_q, frame_done_d;
  logic                      sync_err_q,   sync_err_d;

  logic                      cap_en;
  logic [SLOT_W-1:0]         cap_idx;

  // Slot sequencing: decides which channel (if any) takes the current word.
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;
    cap_en       = 1'b0;
    cap_idx      = SLOT_ZERO;

    if (DIN_VALID) begin
      case (state_q)
        HUNT: begin
          if (FRAME_START) begin
            cap_en  = 1'b1;
            slot_d  = SLOT_ONE;
            state_d = LOCK;
          end
        end

        LOCK: begin
          if (slot_q == SLOT_ZERO) begin
            if (FRAME_START) begin
              cap_en = 1'b1;
              slot_d = SLOT_ONE;
            end else begin
              sync_err_d = 1'b1;
              slot_d     = SLOT_ZERO;
              state_d    = HUNT;
            end
          end else if (FRAME_START) begin
            // Early frame start: the truncated frame is abandoned without FRAME_DONE.
            sync_err_d = 1'b1;
            cap_en     = 1'b1;
            slot_d     = SLOT_ONE;
          end else begin
            cap_en  = 1'b1;
            cap_idx = slot_q;
            if (slot_q == SLOT_LAST) begin
              frame_done_d = 1'b1;
              slot_d       = SLOT_ZERO;
            end else begin
              slot_d = slot_q + SLOT_ONE;
            end
          end
        end

        default: begin
          state_d = HUNT;
          slot_d  = SLOT_ZERO;
        end
      endcase
    end
  end

  always_comb begin
    ch_data_d   = ch_data_q;
    ch_strobe_d = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (cap_en && (cap_idx == SLOT_W'(k))) begin
        ch_data_d[k*WIDTH +: WIDTH] = DIN;
        ch_strobe_d[k]              = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= HUNT;
      slot_q       <= SLOT_ZERO;
      ch_data_q    <= '0;
      ch_strobe_q  <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      ch_data_q    <= ch_data_d;
      ch_strobe_q  <= ch_strobe_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign CH_DATA    = ch_data_q;
  assign CH_STROBE  = ch_strobe_q;
  assign FRAME_DONE = frame_done_q;
  assign LOCKED     = (state_q == LOCK);
  assign SYNC_ERR   = sync_err_q;

endmodule

`default_nettype wire

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: table-driven scoreboard bench for tdm_demux (WIDTH=8, CHANNELS=4).
`default_nettype none

module tb_tdm_demux;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  DIN = '0;
  logic        DIN_VALID = 1'b0;
  logic        FRAME_START = 1'b0;
  logic [31:0] CH_DATA;
  logic [3:0]  CH_STROBE;
  logic        FRAME_DONE;
  logic        LOCKED;
  logic        SYNC_ERR;

  tdm_demux #(.WIDTH(8), .CHANNELS(4)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .DIN        (DIN),
    .DIN_VALID  (DIN_VALID),
    .FRAME_START(FRAME_START),
    .CH_DATA    (CH_DATA),
    .CH_STROBE  (CH_STROBE),
    .FRAME_DONE (FRAME_DONE),
    .LOCKED     (LOCKED),
    .SYNC_ERR   (SYNC_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        rst;
    logic        v;
    logic        fs;
    logic [7:0]  din;
    logic [3:0]  stb;
    logic        done;
    logic        err;
    logic        lk;
    logic [31:0] ch;
  } vec_t;

  vec_t tbl [32];
  vec_t exp_q [$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_no  = 0;

  function automatic vec_t mk(input logic rst, input logic v, input logic fs, input logic [7:0] din,
                              input logic [3:0] stb, input logic done, input logic err,
                              input logic lk, input logic [31:0] ch);
    vec_t r;
    r.rst = rst; r.v = v; r.fs = fs; r.din = din;
    r.stb = stb; r.done = done; r.err = err; r.lk = lk; r.ch = ch;
    return r;
  endfunction

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at step %0d: got %h, expected %h", name, step_no, got, want);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, then score the registered result.
  task automatic step(input vec_t v);
    vec_t e;
    @(negedge CLK);
    RST = v.rst; DIN_VALID = v.v; FRAME_START = v.fs; DIN = v.din;
    exp_q.push_back(v);
    @(posedge CLK);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard at step %0d: queue empty", step_no);
    end else begin
      e = exp_q.pop_front();
      cmp("strobe", 32'(CH_STROBE), 32'(e.stb));
      cmp("frame_done", 32'(FRAME_DONE), 32'(e.done));
      cmp("sync_err", 32'(SYNC_ERR), 32'(e.err));
      cmp("locked", 32'(LOCKED), 32'(e.lk));
      cmp("ch_data", CH_DATA, e.ch);
    end
    step_no++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  words [4];
    logic [31:0] acc;

    //            rst v  fs din    stb     dn err lk ch
    // Reset and a clean back-to-back frame
    tbl[0]  = mk(1, 0, 0, 8'h00, 4'b0000, 0, 0, 0, 32'h00000000);
    tbl[1]  = mk(0, 0, 0, 8'h00, 4'b0000, 0, 0, 0, 32'h00000000);
    tbl[2]  = mk(0, 1, 1, 8'hA1, 4'b0001, 0, 0, 1, 32'h000000A1);
    tbl[3]  = mk(0, 1, 0, 8'hB2, 4'b0010, 0, 0, 1, 32'h0000B2A1);
    tbl[4]  = mk(0, 1, 0, 8'hC3, 4'b0100, 0, 0, 1, 32'h00C3B2A1);
    tbl[5]  = mk(0, 1, 0, 8'hD4, 4'b1000, 1, 0, 1, 32'hD4C3B2A1);
    // Hunting: words without FS are dropped
    tbl[6]  = mk(1, 0, 0, 8'h00, 4'b0000, 0, 0, 0, 32'h00000000);
    tbl[7]  = mk(0, 1, 0, 8'h11, 4'b0000, 0, 0, 0, 32'h00000000);
    tbl[8]  = mk(0, 1, 0, 8'h22, 4'b0000, 0, 0, 0, 32'h00000000);
    tbl[9]  = mk(0, 1, 1, 8'h33, 4'b0001, 0, 0, 1, 32'h00000033);
    tbl[10] = mk(0, 1, 0, 8'h44, 4'b0010, 0, 0, 1, 32'h00004433);
    tbl[11] = mk(0, 1, 0, 8'h55, 4'b0100, 0, 0, 1, 32'h00554433);
    tbl[12] = mk(0, 1, 0, 8'h66, 4'b1000, 1, 0, 1, 32'h66554433);
    // Early resync mid-frame
    tbl[13] = mk(0, 1, 1, 8'h10, 4'b0001, 0, 0, 1, 32'h66554410);
    tbl[14] = mk(0, 1, 0, 8'h20, 4'b0010, 0, 0, 1, 32'h66552010);
    tbl[15] = mk(0, 1, 1, 8'h30, 4'b0001, 0, 1, 1, 32'h66552030);
    tbl[16] = mk(0, 1, 0, 8'h40, 4'b0010, 0, 0, 1, 32'h66554030);
    tbl[17] = mk(0, 1, 0, 8'h50, 4'b0100, 0, 0, 1, 32'h66504030);
    tbl[18] = mk(0, 1, 0, 8'h60, 4'b1000, 1, 0, 1, 32'h60504030);
    // Full frame, then missing FS on slot 0 loses lock
    tbl[19] = mk(0, 1, 1, 8'h01, 4'b0001, 0, 0, 1, 32'h60504001);
    tbl[20] = mk(0, 1, 0, 8'h02, 4'b0010, 0, 0, 1, 32'h60500201);
    tbl[21] = mk(0, 1, 0, 8'h03, 4'b0100, 0, 0, 1, 32'h60030201);
    tbl[22] = mk(0, 1, 0, 8'h04, 4'b1000, 1, 0, 1, 32'h04030201);
    tbl[23] = mk(0, 1, 0, 8'h55, 4'b0000, 0, 1, 0, 32'h04030201);
    tbl[24] = mk(0, 1, 0, 8'h77, 4'b0000, 0, 0, 0, 32'h04030201);
    // Reset mid-frame, then a normal frame
    tbl[25] = mk(0, 1, 1, 8'hAA, 4'b0001, 0, 0, 1, 32'h040302AA);
    tbl[26] = mk(0, 1, 0, 8'hBB, 4'b0010, 0, 0, 1, 32'h0403BBAA);
    tbl[27] = mk(1, 1, 0, 8'hCC, 4'b0000, 0, 0, 0, 32'h00000000);
    tbl[28] = mk(0, 1, 1, 8'h12, 4'b0001, 0, 0, 1, 32'h00000012);
    tbl[29] = mk(0, 1, 0, 8'h34, 4'b0010, 0, 0, 1, 32'h00003412);
    tbl[30] = mk(0, 1, 0, 8'h56, 4'b0100, 0, 0, 1, 32'h00563412);
    tbl[31] = mk(0, 1, 0, 8'h78, 4'b1000, 1, 0, 1, 32'h78563412);

    for (int i = 0; i < 32; i++) step(tbl[i]);

    // Gapped frame: 3 idle cycles after each word, FS toggling while idle must be ignored
    words[0] = 8'hA1; words[1] = 8'hB2; words[2] = 8'hC3; words[3] = 8'hD4;
    step(mk(1, 0, 0, 8'h00, 4'b0000, 0, 0, 0, 32'h00000000));
    acc = 32'h0;
    for (int g = 0; g < 3; g++)
      step(mk(0, 0, 1, 8'hEE, 4'b0000, 0, 0, 0, acc));
    for (int k = 0; k < 4; k++) begin
      acc[k*8 +: 8] = words[k];
      step(mk(0, 1, (k == 0), words[k], 4'b0001 << k, (k == 3), 0, 1, acc));
      for (int g = 0; g < 3; g++)
        step(mk(0, 0, (g == 1), 8'hEE, 4'b0000, 0, 0, 1, acc));
    end
    cmp("gapped_frame_final", CH_DATA, 32'hD4C3B2A1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
